// File: rtl/channel_scheduler.sv
// Round-robin frame scheduler: one frame slot per channel; the granted frame is streamed feature-by-feature to a shared classifier and its result is returned.
// Latency: grant 1 cycle after capture, START 1 cycle, then one feature per accepted cycle; result on core_valid or after TIMEOUT WAIT cycles.
// Backpressure: req_ready[c] is low while slot c holds a frame; ccore_ready low freezes the feature stream in place.
module channel_scheduler #(
    parameter int FEATURES      = 3,
    parameter int FEATURE_WIDTH = 8,
    parameter int CHANNEL_COUNT = 4,
    parameter int MAX_CLUSTERS  = 5,
    parameter int TIMEOUT       = 63,
    localparam int CW      = $clog2(CHANNEL_COUNT),
    localparam int LW      = (MAX_CLUSTERS > 1) ? $clog2(MAX_CLUSTERS) : 1,
    localparam int FRAME_W = FEATURES * FEATURE_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CHANNEL_COUNT-1:0]         req_valid,
    input  logic [CHANNEL_COUNT*FRAME_W-1:0] req_features,
    output logic [CHANNEL_COUNT-1:0]         req_ready,
    output logic                             mem_ready,
    output logic [CW-1:0]                    ch_index,
    output logic [FEATURE_WIDTH-1:0]         feature,
    output logic                             feature_valid,
    input  logic                             ccore_ready,
    input  logic                             core_valid,
    input  logic [LW-1:0]                    core_level,
    input  logic [LW-1:0]                    core_path,
    output logic                             res_valid,
    output logic [CW-1:0]                    res_channel,
    output logic [LW-1:0]                    res_level,
    output logic [LW-1:0]                    res_path,
    output logic                             res_timeout,
    output logic                             busy
);
    localparam int KW = (FEATURES > 1) ? $clog2(FEATURES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [KW-1:0] LAST_K = KW'(FEATURES - 1);

    typedef enum logic [2:0] {IDLE, START, STREAM, WAIT, DONE} state_t;

    state_t                     state;
    logic [CHANNEL_COUNT-1:0]   slot_full;
    logic [FRAME_W-1:0]         slot_dat [CHANNEL_COUNT];
    logic [FRAME_W-1:0]         cur_frame;
    logic [FEATURE_WIDTH-1:0]   frame_feat [FEATURES];
    logic [CW-1:0]              rr_ptr;
    logic [KW-1:0]              feat_idx;
    logic [TW-1:0]              wait_cnt;
    logic                       any_full;
    logic [CW-1:0]              grant_idx;

    assign req_ready = ~slot_full;
    assign busy      = (state != IDLE);
    assign cur_frame = slot_dat[ch_index];

    for (genvar k = 0; k < FEATURES; k++) begin : g_feat
        assign frame_feat[k] = cur_frame[k*FEATURE_WIDTH +: FEATURE_WIDTH];
    end

    for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_slot
        logic               full_q;
        logic [FRAME_W-1:0] dat_q;

        // Slot occupancy: fill on accepted offer, empty at the end of the DONE cycle of its own service.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                full_q <= 1'b0;
            end else if (req_valid[c] && !full_q) begin
                full_q <= 1'b1;
            end else if (state == DONE && ch_index == CW'(c)) begin
                full_q <= 1'b0;
            end
        end

        // Frame payload: only written while the slot is empty, so a granted frame never changes.
        always_ff @(posedge clk) begin
            if (req_valid[c] && !full_q) begin
                dat_q <= req_features[c*FRAME_W +: FRAME_W];
            end
        end

        assign slot_full[c] = full_q;
        assign slot_dat[c]  = dat_q;
    end

    // Round-robin pick: first full slot at or after rr_ptr; scanning downward lets the nearest one win.
    always_comb begin
        int idx;
        any_full  = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int i = CHANNEL_COUNT - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= CHANNEL_COUNT) begin
                idx = idx - CHANNEL_COUNT;
            end
            if (slot_full[CW'(idx)]) begin
                any_full  = 1'b1;
                grant_idx = CW'(idx);
            end
        end
    end

    // Service FSM with registered outputs; each output is updated on the edge that enters the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            ch_index      <= '0;
            feat_idx      <= '0;
            wait_cnt      <= '0;
            mem_ready     <= 1'b0;
            feature_valid <= 1'b0;
            feature       <= '0;
            res_valid     <= 1'b0;
            res_channel   <= '0;
            res_level     <= '0;
            res_path      <= '0;
            res_timeout   <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_full) begin
                        ch_index  <= grant_idx;
                        mem_ready <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    feat_idx      <= '0;
                    feature       <= frame_feat[0];
                    feature_valid <= 1'b1;
                    state         <= STREAM;
                end
                STREAM: begin
                    if (ccore_ready) begin
                        if (feat_idx == LAST_K) begin
                            feature_valid <= 1'b0;
                            wait_cnt      <= '0;
                            state         <= WAIT;
                        end else begin
                            feat_idx <= feat_idx + 1'b1;
                            feature  <= frame_feat[feat_idx + 1'b1];
                        end
                    end
                end
                WAIT: begin
                    if (core_valid) begin
                        res_valid   <= 1'b1;
                        res_channel <= ch_index;
                        res_level   <= core_level;
                        res_path    <= core_path;
                        res_timeout <= 1'b0;
                        mem_ready   <= 1'b0;
                        state       <= DONE;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        res_valid   <= 1'b1;
                        res_channel <= ch_index;
                        res_level   <= '0;
                        res_path    <= '0;
                        res_timeout <= 1'b1;
                        mem_ready   <= 1'b0;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    rr_ptr <= (ch_index == CW'(CHANNEL_COUNT - 1)) ? '0 : ch_index + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
